// File: rtl/mem_access_stage.sv
// Memory-access / writeback stage: accepts one executed instruction, performs any
// load/store over a req/ack byte-lane port, and emits one registered writeback beat.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        store,
    input  logic        load,
    input  logic        we_reg,
    input  logic [2:0]  funct3,
    input  logic [31:0] ls_mem_addr,
    input  logic [31:0] wd_mem,
    input  logic [31:0] wd_reg,
    input  logic [4:0]  rd_in,
    input  logic [31:0] next_pc,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] wb_next_pc,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dbg_state
);

    // Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
    // the memory port holds dmem_req and its fields until the edge where dmem_ack is 1.
    typedef enum logic {S_IDLE = 1'b0, S_MEM = 1'b1} state_t;

    localparam logic [31:0] TMAX = 32'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;

    logic        f3_legal, misaligned, bad_access;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic [31:0] rshift, load_val;

    always_comb begin
        f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = ls_mem_addr[0];
            2'b10:   misaligned = |ls_mem_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        bad_access = !f3_legal || misaligned || (load && store);
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        st_wdata = wd_mem;
        st_be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{wd_mem[7:0]}};
                st_be    = 4'b0001 << ls_mem_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{wd_mem[15:0]}};
                st_be    = ls_mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = wd_mem;
                st_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rshift   = dmem_rdata >> {off_q, 3'b000};
        load_val = dmem_rdata;
        case (f3_q)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_val = {24'd0, rshift[7:0]};
            3'b101:  load_val = {16'd0, rshift[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        off_d      = off_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'd0;
        wb_pc_d    = 32'd0;
        mis_d      = 1'b0;
        bus_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pc_d = next_pc;
                    if (!load && !store) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = we_reg && (rd_in != 5'd0);
                        wb_rd_d    = rd_in;
                        wb_data_d  = wd_reg;
                        wb_pc_d    = next_pc;
                    end else if (bad_access) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        wb_pc_d    = next_pc;
                        mis_d      = 1'b1;
                    end else begin
                        state_d = S_MEM;
                        cnt_d   = 32'd0;
                        addr_d  = {ls_mem_addr[31:2], 2'b00};
                        off_d   = ls_mem_addr[1:0];
                        we_d    = store;
                        wdata_d = store ? st_wdata : 32'd0;
                        be_d    = store ? st_be : 4'b1111;
                        f3_d    = funct3;
                        rd_d    = rd_in;
                    end
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_pc_d    = pc_q;
                    if (!we_q) begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_data_d = load_val;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TMAX)) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_pc_d    = pc_q;
                    bus_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q    <= S_IDLE;
            cnt_q      <= 32'd0;
            addr_q     <= 32'd0;
            off_q      <= 2'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            pc_q       <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_pc_q    <= 32'd0;
            mis_q      <= 1'b0;
            bus_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            mis_q      <= mis_d;
            bus_q      <= bus_d;
        end
    end

    // Memory fields read as zero outside MEM so the port is quiet when idle.
    always_comb begin
        in_ready     = (state_q == S_IDLE);
        dmem_req     = (state_q == S_MEM);
        dmem_we      = dmem_req && we_q;
        dmem_addr    = dmem_req ? addr_q : 32'd0;
        dmem_wdata   = dmem_req ? wdata_q : 32'd0;
        dmem_be      = dmem_req ? be_q : 4'd0;
        wb_valid     = wb_valid_q;
        wb_we        = wb_we_q;
        wb_rd        = wb_rd_q;
        wb_data      = wb_data_q;
        wb_next_pc   = wb_pc_q;
        misalign_err = mis_q;
        bus_err      = bus_q;
        dbg_state    = state_q;
    end

endmodule
